cpu_op_sequencer: RTL and testbench

Sequences the 4-switch CPU datapath by replaying a short programmed list of 4-bit operation codes.
- Latches the switch inputs at start and presents them stable to the CPU for the whole run.
- Issues each opcode with a one-cycle enable strobe, waits a fixed latency, then captures the CPU's 1-bit out into a result vector.
- Sits between the board switches/host and the CPU instance.

---
 rtl/cpu_op_sequencer_pkg.sv | 20 ++
 rtl/cpu_op_sequencer_if.sv | 34 +++
 rtl/cpu_op_sequencer_op_store.sv | 28 ++
 rtl/cpu_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_op_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_op_sequencer_pkg.sv
// Shared types and constants for the CPU operation sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } seq_state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_AND = 4'h1;
  localparam logic [3:0] OP_OR  = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;

  localparam int SW_W = 4;

endpackage

// File: rtl/cpu_op_sequencer_if.sv
// Host/CPU-facing bundle of the sequencer: program port, run control and CPU drive.
interface cpu_op_sequencer_if #(
    parameter int PROG_DEPTH = 8,
    parameter int OP_W       = 4
);
    import cpu_seq_pkg::*;

    localparam int AW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

    logic                  start;
    logic                  prog_we;
    logic [AW-1:0]         prog_addr;
    logic [OP_W-1:0]       prog_data;
    logic [AW:0]           prog_len;
    logic [SW_W-1:0]       sw_in;
    logic                  cpu_out;
    logic [SW_W-1:0]       sw_out;
    logic [OP_W-1:0]       operation;
    logic                  enable;
    logic                  busy;
    logic                  done;
    logic [PROG_DEPTH-1:0] result;

    modport master (
        output start, prog_we, prog_addr, prog_data, prog_len, sw_in, cpu_out,
        input  sw_out, operation, enable, busy, done, result
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_data, prog_len, sw_in, cpu_out,
        output sw_out, operation, enable, busy, done, result
    );

endinterface

// File: rtl/cpu_op_sequencer_op_store.sv
// Opcode register file: one write port, one combinational read port, cleared on reset.
module op_store #(
    parameter int DEPTH = 8,
    parameter int W     = 4,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [DEPTH-1:0][W-1:0] mem_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_op_sequencer.sv
// Replays a programmed opcode list into the CPU and collects its 1-bit results.
// Optional SEQ_LOOP_EN: with start held, the run restarts straight after DONE.
module cpu_op_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int PROG_DEPTH  = 8,
    parameter int OP_W        = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         clock,
    input  logic         reset,
    cpu_op_sequencer_if.slave bus
);

    localparam int         AW        = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
    localparam int         LW        = AW + 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    seq_state_e            state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [LW-1:0]         len_q, len_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [SW_W-1:0]       sw_q, sw_d;
    logic [PROG_DEPTH-1:0] res_q, res_d;
    logic                  loop_q, loop_d;

    logic [OP_W-1:0]       rd_op;
    logic [OP_W-1:0]       op_o;
    logic                  en_o, done_o, busy_o;
    logic [LW-1:0]         len_sat;
    logic                  last_op;

    assign len_sat = (bus.prog_len > LW'(PROG_DEPTH)) ? LW'(PROG_DEPTH) : bus.prog_len;
    assign last_op = ({1'b0, idx_q} == (len_q - 1'b1));

    // Writes only land while idle, so the program is frozen for the whole run.
    op_store #(
        .DEPTH (PROG_DEPTH),
        .W     (OP_W),
        .AW    (AW)
    ) u_store (
        .clock   (clock),
        .reset   (reset),
        .we_i    (bus.prog_we && (state_q == S_IDLE)),
        .waddr_i (bus.prog_addr),
        .wdata_i (bus.prog_data),
        .raddr_i (idx_q),
        .rdata_o (rd_op)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            sw_q    <= '0;
            res_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            res_q   <= res_d;
            loop_q  <= loop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        res_d   = res_q;
        loop_d  = loop_q;
        op_o    = '0;
        en_o    = 1'b0;
        done_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sw_d   = bus.sw_in;
                    res_d  = '0;
                    idx_d  = '0;
                    loop_d = 1'b0;
                    if (len_sat == '0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d   = len_sat;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                op_o    = rd_op;
                en_o    = 1'b1;
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                op_o = rd_op;
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CAPTURE: begin
                op_o         = rd_op;
                res_d[idx_q] = bus.cpu_out;
                if (last_op) begin
                    state_d = S_DONE;
`ifdef SEQ_LOOP_EN
                    loop_d  = bus.start;
`endif
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
`ifdef SEQ_LOOP_EN
                // Looping pass skips IDLE; switches are re-sampled for the new pass.
                if (loop_q) begin
                    idx_d   = '0;
                    sw_d    = bus.sw_in;
                    loop_d  = 1'b0;
                    state_d = S_ISSUE;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_CAPTURE) ||
                    ((state_q == S_DONE) && loop_q);

    assign bus.sw_out    = sw_q;
    assign bus.operation = op_o;
    assign bus.enable    = en_o;
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.result    = res_q;

endmodule

// File: tb/tb_cpu_op_sequencer.sv
// Scoreboard bench for cpu_op_sequencer; the CPU is modelled as parity of the opcode.
module tb_cpu_op_sequencer;

  localparam int PD  = 8;
  localparam int OW  = 4;
  localparam int WC  = 2;
  localparam int PER = WC + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cpu_op_sequencer_if #(.PROG_DEPTH(PD), .OP_W(OW)) bus ();

  cpu_op_sequencer #(.PROG_DEPTH(PD), .OP_W(OW), .WAIT_CYCLES(WC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.cpu_out = ^bus.operation;

  int checks = 0;
  int failures = 0;

  logic [OW-1:0] pm [PD];

  int            exp_en [$];
  logic [OW-1:0] exp_op [$];
  logic [PD-1:0] exp_res [$];
  int            exp_done_k;

  int            obs_en [$];
  logic [OW-1:0] obs_op [$];
  int            obs_done_k, obs_busy, obs_done_n;
  logic [PD-1:0] obs_res;
  logic [3:0]    obs_sw;

  task automatic write_prog(input int addr, input logic [OW-1:0] data);
    @(negedge clock);
    bus.prog_we = 1'b1; bus.prog_addr = 3'(addr); bus.prog_data = data;
    @(negedge clock);
    bus.prog_we = 1'b0;
    pm[addr] = data;
  endtask

  function automatic void push_expected(input int len);
    logic [PD-1:0] r;
    int n;
    n = (len > PD) ? PD : len;
    r = '0;
    exp_en.delete(); exp_op.delete();
    for (int i = 0; i < n; i++) begin
      exp_en.push_back(1 + i * PER);
      exp_op.push_back(pm[i]);
      r[i] = ^pm[i];
    end
    exp_res.push_back(r);
    exp_done_k = n * PER + 1;
  endfunction

  // Cycle k counts posedges after the edge that accepts start.
  task automatic run_obs(input logic [3:0] sw, input logic [3:0] len, input int max_cyc, input bit poke);
    obs_en.delete(); obs_op.delete();
    obs_done_k = -1; obs_busy = 0; obs_done_n = 0; obs_res = '0; obs_sw = '0;
    @(negedge clock);
    bus.sw_in = sw; bus.prog_len = len; bus.start = 1'b1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clock);
      bus.start = 1'b0; bus.prog_we = 1'b0;
      if (poke && (k == 3 || k == 6)) begin
        bus.start = 1'b1;
        if (k == 3) begin bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 4'hF; end
      end
      if (bus.enable) begin obs_en.push_back(k); obs_op.push_back(bus.operation); end
      if (bus.busy) obs_busy++;
      if (bus.done) begin
        obs_done_n++; obs_done_k = k; obs_res = bus.result; obs_sw = bus.sw_out;
        break;
      end
    end
    bus.start = 1'b0; bus.prog_we = 1'b0;
  endtask

  task automatic test_reset;
    logic [PD-1:0] r;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.sw_out, bus.operation, bus.enable, bus.busy, bus.done, bus.result} !== '0) begin
      failures++; $display("FAIL reset_outputs: got %h exp 0",
        {bus.sw_out, bus.operation, bus.enable, bus.busy, bus.done, bus.result});
    end
    reset = 1'b0;
    write_prog(0, 4'h7);
    @(negedge clock);
    reset = 1'b1;
    #1;
    for (int i = 0; i < PD; i++) pm[i] = '0;
    checks++;
    if ({bus.sw_out, bus.operation, bus.enable, bus.busy, bus.done, bus.result} !== '0) begin
      failures++; $display("FAIL reset_idle_outputs: got %h exp 0",
        {bus.sw_out, bus.operation, bus.enable, bus.busy, bus.done, bus.result});
    end
    @(negedge clock);
    reset = 1'b0;
    push_expected(1);
    run_obs(4'hA, 4'd1, 20, 1'b0);
    checks++;
    if (obs_op.size() != 1 || obs_op[0] !== 4'h0) begin
      failures++; $display("FAIL reset_prog_cleared: got %0d ops first %h exp 1 op 0", obs_op.size(), obs_op.size() ? obs_op[0] : 4'hx);
    end
    r = exp_res.pop_front();
    checks++;
    if (obs_done_k != exp_done_k || obs_res !== r) begin
      failures++; $display("FAIL reset_run: got k=%0d res=%b exp k=%0d res=%b", obs_done_k, obs_res, exp_done_k, r);
    end
  endtask

  task automatic test_basic;
    logic [PD-1:0] r;
    write_prog(0, 4'h1); write_prog(1, 4'h2); write_prog(2, 4'h3);
    push_expected(3);
    run_obs(4'b0101, 4'd3, 40, 1'b0);
    while (exp_en.size() > 0) begin
      int e; logic [OW-1:0] eo;
      e = exp_en.pop_front(); eo = exp_op.pop_front();
      checks++;
      if (obs_en.size() == 0) begin
        failures++; $display("FAIL basic_enable: got none exp cycle %0d", e);
      end else begin
        int g; logic [OW-1:0] go;
        g = obs_en.pop_front(); go = obs_op.pop_front();
        if (g != e || go !== eo) begin
          failures++; $display("FAIL basic_enable: got cycle %0d op %h exp cycle %0d op %h", g, go, e, eo);
        end
      end
    end
    checks++;
    if (obs_en.size() != 0) begin failures++; $display("FAIL basic_extra_enable: got %0d extra exp 0", obs_en.size()); end
    r = exp_res.pop_front();
    checks++;
    if (obs_res !== r) begin failures++; $display("FAIL basic_result: got %b exp %b", obs_res, r); end
    checks++;
    if (obs_done_k != exp_done_k) begin failures++; $display("FAIL basic_done_cycle: got %0d exp %0d", obs_done_k, exp_done_k); end
    checks++;
    if (obs_sw !== 4'b0101 || obs_busy != exp_done_k - 1) begin
      failures++; $display("FAIL basic_sw_busy: got sw=%b busy=%0d exp sw=0101 busy=%0d", obs_sw, obs_busy, exp_done_k - 1);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== r || bus.operation !== '0) begin
      failures++; $display("FAIL basic_hold: got done=%b busy=%b res=%b op=%h exp 0 0 %b 0",
        bus.done, bus.busy, bus.result, bus.operation, r);
    end
  endtask

  task automatic test_len_zero;
    run_obs(4'b1001, 4'd0, 10, 1'b0);
    checks++;
    if (obs_done_k != 1 || obs_en.size() != 0 || obs_res !== '0 || obs_sw !== 4'b1001) begin
      failures++; $display("FAIL len_zero: got k=%0d en=%0d res=%b sw=%b exp k=1 en=0 res=0 sw=1001",
        obs_done_k, obs_en.size(), obs_res, obs_sw);
    end
  endtask

  task automatic test_busy_ignore;
    logic [PD-1:0] r;
    push_expected(2);
    run_obs(4'b0011, 4'd2, 30, 1'b1);
    r = exp_res.pop_front();
    checks++;
    if (obs_done_k != exp_done_k || obs_res !== r || obs_en.size() != 2) begin
      failures++; $display("FAIL busy_run: got k=%0d res=%b en=%0d exp k=%0d res=%b en=2",
        obs_done_k, obs_res, obs_en.size(), exp_done_k, r);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_no_rerun: got busy=%b exp 0", bus.busy); end
    push_expected(1);
    run_obs(4'b0011, 4'd1, 20, 1'b0);
    void'(exp_res.pop_front());
    checks++;
    if (obs_op.size() != 1 || obs_op[0] !== exp_op[0]) begin
      failures++; $display("FAIL busy_write_ignored: got op %h exp %h", obs_op.size() ? obs_op[0] : 4'hx, exp_op[0]);
    end
  endtask

  task automatic test_saturate;
    logic [PD-1:0] r;
    write_prog(3, 4'h4); write_prog(4, 4'h7); write_prog(5, 4'h0);
    write_prog(6, 4'h8); write_prog(7, 4'h5);
    push_expected(15);
    run_obs(4'b1111, 4'd15, 60, 1'b0);
    r = exp_res.pop_front();
    checks++;
    if (obs_done_k != exp_done_k || obs_en.size() != PD || obs_res !== r) begin
      failures++; $display("FAIL saturate: got k=%0d en=%0d res=%b exp k=%0d en=%0d res=%b",
        obs_done_k, obs_en.size(), obs_res, exp_done_k, PD, r);
    end
  endtask

`ifndef SEQ_LOOP_EN
  task automatic test_back_to_back;
    int en_k [$];
    int dn;
    dn = 0;
    @(negedge clock);
    bus.prog_len = 4'd1; bus.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (bus.enable) en_k.push_back(k);
      if (bus.done) dn++;
    end
    bus.start = 1'b0;
    checks++;
    if (en_k.size() != 2 || en_k[0] != 1 || en_k[1] != 1 + PER + 2 || dn != 1) begin
      failures++; $display("FAIL retrigger: got en=%0d first=%0d second=%0d done=%0d exp en=2 1 %0d done=1",
        en_k.size(), en_k.size() > 0 ? en_k[0] : -1, en_k.size() > 1 ? en_k[1] : -1, dn, 1 + PER + 2);
    end
    repeat (8) @(negedge clock);
  endtask
`else
  task automatic test_back_to_back;
    logic [3:0] swv [3];
    logic [3:0] got_sw [$];
    int dk [$];
    int gaps;
    swv[0] = 4'h3; swv[1] = 4'hC; swv[2] = 4'h9;
    gaps = 0;
    @(negedge clock);
    bus.prog_len = 4'd1; bus.sw_in = swv[0]; bus.start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (bus.done) begin
        dk.push_back(k); got_sw.push_back(bus.sw_out);
        if (dk.size() < 3) bus.sw_in = swv[dk.size()];
        if (dk.size() == 2) bus.start = 1'b0;
        if (dk.size() == 3) break;
      end else if (!bus.busy) gaps++;
    end
    bus.start = 1'b0;
    checks++;
    if (dk.size() != 3 || gaps != 0) begin
      failures++; $display("FAIL loop_passes: got done=%0d busy_gaps=%0d exp 3 0", dk.size(), gaps);
    end
    for (int i = 0; i < 3 && i < got_sw.size(); i++) begin
      checks++;
      if (got_sw[i] !== swv[i] || dk[i] != (i + 1) * (PER + 1)) begin
        failures++; $display("FAIL loop_pass%0d: got sw=%h k=%0d exp sw=%h k=%0d", i, got_sw[i], dk[i], swv[i], (i + 1) * (PER + 1));
      end
    end
    repeat (3) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL loop_stop: got busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
  endtask
`endif

  task automatic test_reset_midrun;
    int dn;
    dn = 0;
    @(negedge clock);
    bus.sw_in = 4'h6; bus.prog_len = 4'd3; bus.start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    #1;
    for (int i = 0; i < PD; i++) pm[i] = '0;
    checks++;
    if (bus.busy !== 1'b0 || bus.enable !== 1'b0 || bus.sw_out !== '0 || bus.result !== '0) begin
      failures++; $display("FAIL midrun_reset: got busy=%b en=%b sw=%h res=%b exp all 0",
        bus.busy, bus.enable, bus.sw_out, bus.result);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      if (bus.done || bus.busy) dn++;
    end
    checks++;
    if (dn != 0) begin failures++; $display("FAIL midrun_no_done: got %0d active cycles exp 0", dn); end
  endtask

  initial begin
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.prog_len = '0; bus.sw_in = '0;
    for (int i = 0; i < PD; i++) pm[i] = '0;
    test_reset();
    test_basic();
    test_len_zero();
    test_busy_ignore();
    test_saturate();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
